uart_rx_ctrl: RTL and testbench



---
 rtl/uart_rx_ctrl.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: framed RS232 receive sequencer with valid/ack byte handoff.
// Finds the start bit, samples each bit mid-period, checks the stop bit and
// flags framing errors and overruns.
// Optional even-parity bit, parity state and parity_err port: define RX_PARITY_EN.
module uart_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state, state_nx;
    logic                 rx_m, rx_s;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [BW-1:0]        idx, idx_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 done, ferr_nx;
`ifdef RX_PARITY_EN
    logic                 perr_nx;
`endif

    assign busy = (state != IDLE);

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            shreg <= shreg_nx;
        end
    end

    // Next-state logic: the timer restarts at every sample point.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        shreg_nx = shreg;
        done     = 1'b0;
        ferr_nx  = 1'b0;
`ifdef RX_PARITY_EN
        perr_nx  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!rx_s) state_nx = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_nx   = '0;
                    shreg_nx = {rx_s, shreg[DATA_BITS-1:1]};
                    idx_nx   = idx + 1'b1;
                    if (idx == IDX_LAST) begin
`ifdef RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_FULL) begin
                    cnt_nx   = '0;
                    perr_nx  = (rx_s != ^shreg);
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_nx = '0;
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Byte handoff: deliver on completion, drop with overrun if unread, ack clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= ferr_nx;
`ifdef RX_PARITY_EN
            parity_err <= perr_nx;
`endif
            if (done && (!data_valid || rd_ack)) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                overrun    <= 1'b0;
            end else if (done) begin
                overrun <= 1'b1;
            end else if (rd_ack && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: table of frames plus hand-written corner sequences.
// Expected bytes go to a queue when a frame is driven and are popped when the
// receiver presents a byte. Define RX_PARITY_EN to build the parity variant.
module tb_uart_rx_ctrl;
    localparam int N  = 16;
    localparam int H  = N / 2;
    localparam int DB = 8;
`ifdef RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // rx pin drive to first visible data_valid edge: 2 sync + stop sample + 1
    localparam int LAT = 2 + H + (DB + 1 + P) * N + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, frame_err, overrun, busy;
`ifdef RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
    logic       perr_q = 1'b0;
    int         perr_cnt = 0;
`endif

    uart_rx_ctrl #(.CLKS_PER_BIT(N), .DATA_BITS(DB)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rd_ack(rd_ack),
        .data_out(data_out),
        .data_valid(data_valid),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
`ifdef RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    // Free-running cycle count used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    int         passed = 0;
    int         total = 0;
    int         start_cyc = 0;
    int         ferr_cnt = 0;
    logic [7:0] sb[$];
    logic       dv_q = 1'b0;
    logic [7:0] do_q = '0;
    logic       ferr_q = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                      name, act, act, exp, exp, $time);
    endtask

    // Delivery scoreboard and pulse-width monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid && (!dv_q || data_out != do_q)) begin
                chk("delivery_expected", (sb.size() != 0) ? 1 : 0, 1);
                if (sb.size() != 0) begin
                    logic [7:0] e;
                    e = sb.pop_front();
                    chk("data_out", data_out, e);
                    chk("latency", cyc - start_cyc, LAT);
                end
            end
            if (frame_err) begin
                ferr_cnt++;
                chk("frame_err_width", ferr_q, 0);
            end
`ifdef RX_PARITY_EN
            if (parity_err) begin
                perr_cnt++;
                chk("parity_err_width", perr_q, 0);
            end
`endif
        end
        dv_q   = data_valid;
        do_q   = data_out;
        ferr_q = frame_err;
`ifdef RX_PARITY_EN
        perr_q = parity_err;
`endif
    end

    task automatic send_frame(input logic [7:0] d, input logic stopb, input logic ack_cmp);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        fork
            begin
                rx = 1'b0;
                for (int i = 0; i < DB; i++) begin
                    repeat (N) @(posedge clk);
                    #1 rx = d[i];
                end
`ifdef RX_PARITY_EN
                repeat (N) @(posedge clk);
                #1 rx = (^d) ^ par_flip;
`endif
                repeat (N) @(posedge clk);
                #1 rx = stopb;
                repeat (N) @(posedge clk);
                #1;
            end
            begin
                if (ack_cmp) begin
                    repeat (LAT - 1) @(posedge clk);
                    #1 rd_ack = 1'b1;
                    @(posedge clk);
                    #1 rd_ack = 1'b0;
                end
            end
        join
    endtask

    task automatic do_ack;
        @(posedge clk);
        #1 rd_ack = 1'b1;
        @(posedge clk);
        #1 rd_ack = 1'b0;
        @(negedge clk);
        chk("ack_clears_valid", data_valid, 0);
        chk("ack_clears_overrun", overrun, 0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       ack_cmp;
        logic       deliver;
        logic       ack_after;
        logic       exp_ovr;
        logic [7:0] exp_do;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int f0;
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[2] = '{8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
        vecs[3] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
        vecs[4] = '{8'h7E, 1'b1, 1'b1, 1'b1, 1'b0, 8'h7E};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // table-driven frames
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].deliver) sb.push_back(vecs[v].d);
            send_frame(vecs[v].d, 1'b1, vecs[v].ack_cmp);
            @(negedge clk);
            chk("vec_data_out", data_out, vecs[v].exp_do);
            chk("vec_valid", data_valid, 1);
            chk("vec_overrun", overrun, vecs[v].exp_ovr);
            chk("vec_busy_low", busy, 0);
            chk("vec_sb_drained", sb.size(), 0);
            if (vecs[v].ack_after) do_ack();
        end
        chk("no_frame_err_good", ferr_cnt, 0);

        // false start: 4-cycle glitch
        f0 = ferr_cnt;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("glitch_in_start", busy, 1);
        rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy", busy, 0);
        chk("glitch_valid", data_valid, 0);
        chk("glitch_ferr", ferr_cnt, f0);

        // framing error, line held low
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("ferr_count", ferr_cnt, f0 + 1);
        chk("ferr_valid", data_valid, 0);
        chk("ferr_wait_busy", busy, 1);
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("ferr_idle_after_high", busy, 0);
        chk("ferr_count_final", ferr_cnt, f0 + 1);

`ifdef RX_PARITY_EN
        // parity mismatch still delivers the byte
        chk("perr_none_yet", perr_cnt, 0);
        par_flip = 1'b1;
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        par_flip = 1'b0;
        @(negedge clk);
        chk("perr_count", perr_cnt, 1);
        chk("perr_data_out", data_out, 8'h07);
        chk("perr_valid", data_valid, 1);
        do_ack();
`endif

        // reset in the middle of a frame with a byte pending
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        fork
            send_frame(8'hF0, 1'b1, 1'b0);
            begin
                @(posedge clk);
                repeat (2 + H + 4 * N + 4) @(posedge clk);
                #1;
                chk("mid_busy", busy, 1);
                chk("mid_valid_pending", data_valid, 1);
                #2 rst = 1'b1;
                #1;
                chk("mid_rst_data_out", data_out, 0);
                chk("mid_rst_valid", data_valid, 0);
                chk("mid_rst_overrun", overrun, 0);
                chk("mid_rst_frame_err", frame_err, 0);
                chk("mid_rst_busy", busy, 0);
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", data_valid, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
